// File: rtl/pll_pkg.sv
// Shared types for the VCO band-calibration controller: FSM states and band select.
package pll_pkg;

  localparam int NUM_BANDS = 4;

  typedef logic [1:0] band_t;

  localparam band_t LAST_BAND = band_t'(NUM_BANDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pll_edge_sync.sv
// Synchronizes the asynchronous VCO square wave into clk and emits a one-cycle rising-edge pulse.
// Edge-to-pulse latency is SYNC_STAGES cycles; free-running, no flow control.
module pll_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vco_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vco_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pll_band_cal.sv
// Band calibration: per band settle, count VCO edges over a gate window, pick the lowest band meeting target.
// Per band SETTLE_CYC+G+1 cycles; start is ignored while busy, ena low aborts to IDLE.
module pll_band_cal
  import pll_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SETTLE_CYC  = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              vco_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [CNT_W-1:0]  target,
  output logic [1:0]        band,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              overflow
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t             state, next;
  logic [TMR_W-1:0]   tmr, gate_last;
  logic [GATE_W-1:0]  gate_q;
  logic [CNT_W-1:0]   target_q, edge_cnt;
  logic               edge_ovf, rise, meet;
  band_t              band_q;

  pll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .vco_in (vco_in),
    .rise   (rise)
  );

  // A zero gate still measures for one cycle.
  assign gate_last = (gate_q == '0) ? '0 : TMR_W'(gate_q) - TMR_W'(1);
  assign meet      = (edge_cnt >= target_q);

  assign band = band_q;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:    if (start && ena) next = ST_SETTLE;
      ST_SETTLE:  if (!ena) next = ST_IDLE;
                  else if (tmr == SETTLE_LAST) next = ST_MEASURE;
      ST_MEASURE: if (!ena) next = ST_IDLE;
                  else if (tmr == gate_last) next = ST_EVAL;
      ST_EVAL:    if (!ena) next = ST_IDLE;
                  else if (meet || band_q == LAST_BAND) next = ST_DONE;
                  else next = ST_SETTLE;
      ST_DONE:    next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  // Shared settle/gate timer restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               tmr <= '0;
    else if (next != state)   tmr <= '0;
    else if (state != ST_IDLE) tmr <= tmr + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      edge_ovf <= 1'b0;
    end else if (state != ST_MEASURE && next == ST_MEASURE) begin
      edge_cnt <= '0;
      edge_ovf <= 1'b0;
    end else if (state == ST_MEASURE && rise) begin
      if (edge_cnt == CNT_MAX) edge_ovf <= 1'b1;
      else                     edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      band_q   <= '0;
      count    <= '0;
      locked   <= 1'b0;
      overflow <= 1'b0;
      gate_q   <= '0;
      target_q <= '0;
    end else if (state != ST_IDLE && !ena) begin
      locked <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start && ena) begin
          gate_q   <= gate_cycles;
          target_q <= target;
          band_q   <= '0;
          locked   <= 1'b0;
        end
        ST_EVAL: begin
          count    <= edge_cnt;
          overflow <= edge_ovf;
          if (meet)                    locked <= 1'b1;
          else if (band_q != LAST_BAND) band_q <= band_q + band_t'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
